// File: rtl/call_controller.sv
// Call-control engine between the UI command port and the network packet layer.
// One call at a time; a single-entry transmit register holds outgoing signalling.
module call_controller #(
    parameter logic [7:0]  MY_ADDR      = 8'h01,
    parameter logic [15:0] RING_TIMEOUT = 16'd50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic [2:0] cmd,
    input  logic [7:0] cmd_addr,
    output logic       cmd_ready,
    output logic       net_tx_valid,
    output logic [2:0] net_tx_type,
    output logic [7:0] net_tx_dst,
    input  logic       net_tx_ready,
    input  logic       net_rx_valid,
    input  logic [2:0] net_rx_type,
    input  logic [7:0] net_rx_src,
    output logic       net_rx_ready,
    output logic       init,
    output logic       incoming_call,
    output logic [7:0] inc_address,
    output logic [2:0] call_state,
    output logic [7:0] peer_addr
);
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_INCOMING = 3'd1;
    localparam logic [2:0] ST_OUTGOING = 3'd2;
    localparam logic [2:0] ST_BUSY     = 3'd3;
    localparam logic [2:0] ST_INIT     = 3'd5;

    localparam logic [2:0] MSG_INIT     = 3'd0;
    localparam logic [2:0] MSG_CALL_REQ = 3'd1;
    localparam logic [2:0] MSG_CALL_ACK = 3'd2;
    localparam logic [2:0] MSG_CALL_NAK = 3'd3;
    localparam logic [2:0] MSG_CALL_END = 3'd4;

    localparam logic [2:0] CMD_INIT   = 3'd0;
    localparam logic [2:0] CMD_CALL   = 3'd1;
    localparam logic [2:0] CMD_ACCEPT = 3'd2;
    localparam logic [2:0] CMD_REJECT = 3'd3;
    localparam logic [2:0] CMD_END    = 3'd4;

    localparam logic [7:0]  BCAST_ADDR = 8'hFF;
    localparam logic [15:0] TIMER_LAST = RING_TIMEOUT - 16'd1;

    logic [2:0]  state, state_n;
    logic [15:0] timer;
    logic        tx_pending;
    logic        rx_fire, cmd_fire, ringing, expired, from_peer;
    logic        init_n, load_tx, timer_clr;
    logic [7:0]  peer_n, inc_n, tx_dst_n;
    logic [2:0]  tx_type_n;

    assign net_tx_valid  = tx_pending;
    assign net_rx_ready  = ~tx_pending;
    assign cmd_ready     = ~tx_pending & ~net_rx_valid;
    assign rx_fire       = net_rx_valid & ~tx_pending;
    assign cmd_fire      = cmd_valid & cmd_ready;
    assign ringing       = (state == ST_INCOMING) || (state == ST_OUTGOING);
    assign expired       = ringing && (timer >= TIMER_LAST) && !tx_pending;
    assign from_peer     = (net_rx_src == peer_addr);
    assign incoming_call = (state == ST_INCOMING);
    assign call_state    = state;

    // Received messages outrank commands, which outrank ring expiry; one event per cycle.
    always_comb begin
        state_n   = state;
        init_n    = init;
        peer_n    = peer_addr;
        inc_n     = inc_address;
        load_tx   = 1'b0;
        tx_type_n = net_tx_type;
        tx_dst_n  = net_tx_dst;
        timer_clr = 1'b0;
        if (rx_fire) begin
            if (state == ST_INIT) begin
                if (net_rx_type == MSG_INIT) begin
                    init_n  = 1'b1;
                    state_n = ST_IDLE;
                end
            end else if (state == ST_IDLE) begin
                if (net_rx_type == MSG_CALL_REQ) begin
                    peer_n    = net_rx_src;
                    inc_n     = net_rx_src;
                    timer_clr = 1'b1;
                    state_n   = ST_INCOMING;
                end
            end else if (net_rx_type == MSG_CALL_REQ && !from_peer) begin
                load_tx   = 1'b1;
                tx_type_n = MSG_CALL_NAK;
                tx_dst_n  = net_rx_src;
            end else if (from_peer) begin
                case (state)
                    ST_INCOMING: if (net_rx_type == MSG_CALL_END) state_n = ST_IDLE;
                    ST_OUTGOING: begin
                        if (net_rx_type == MSG_CALL_ACK) state_n = ST_BUSY;
                        else if (net_rx_type == MSG_CALL_NAK) state_n = ST_IDLE;
                    end
                    ST_BUSY:     if (net_rx_type == MSG_CALL_END) state_n = ST_IDLE;
                    default:     ;
                endcase
            end
        end else if (cmd_fire) begin
            case (state)
                ST_INIT: if (cmd == CMD_INIT) begin
                    load_tx   = 1'b1;
                    tx_type_n = MSG_INIT;
                    tx_dst_n  = BCAST_ADDR;
                    init_n    = 1'b1;
                    state_n   = ST_IDLE;
                end
                ST_IDLE: if (cmd == CMD_CALL && cmd_addr != MY_ADDR && cmd_addr != BCAST_ADDR) begin
                    peer_n    = cmd_addr;
                    load_tx   = 1'b1;
                    tx_type_n = MSG_CALL_REQ;
                    tx_dst_n  = cmd_addr;
                    timer_clr = 1'b1;
                    state_n   = ST_OUTGOING;
                end
                ST_INCOMING: if (cmd == CMD_ACCEPT || cmd == CMD_REJECT) begin
                    load_tx   = 1'b1;
                    tx_type_n = (cmd == CMD_ACCEPT) ? MSG_CALL_ACK : MSG_CALL_NAK;
                    tx_dst_n  = peer_addr;
                    state_n   = (cmd == CMD_ACCEPT) ? ST_BUSY : ST_IDLE;
                end
                ST_OUTGOING, ST_BUSY: if (cmd == CMD_END) begin
                    load_tx   = 1'b1;
                    tx_type_n = MSG_CALL_END;
                    tx_dst_n  = peer_addr;
                    state_n   = ST_IDLE;
                end
                default: ;
            endcase
        end else if (expired) begin
            load_tx   = 1'b1;
            tx_type_n = (state == ST_INCOMING) ? MSG_CALL_NAK : MSG_CALL_END;
            tx_dst_n  = peer_addr;
            state_n   = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_INIT;
            init        <= 1'b0;
            peer_addr   <= 8'h00;
            inc_address <= 8'h00;
            tx_pending  <= 1'b0;
            net_tx_type <= 3'd0;
            net_tx_dst  <= 8'h00;
            timer       <= 16'd0;
        end else begin
            state       <= state_n;
            init        <= init_n;
            peer_addr   <= peer_n;
            inc_address <= inc_n;
            if (load_tx) begin
                tx_pending  <= 1'b1;
                net_tx_type <= tx_type_n;
                net_tx_dst  <= tx_dst_n;
            end else if (net_tx_ready) begin
                tx_pending <= 1'b0;
            end
            // Saturating ring timer so a long-blocked expiry cannot wrap and be lost.
            if (timer_clr)
                timer <= 16'd0;
            else if (ringing && timer != 16'hFFFF)
                timer <= timer + 16'd1;
        end
    end
endmodule

// File: tb/tb_call_controller.sv
// Bench for call_controller: directed call-flow scenarios plus randomized traffic
// checked against an event-level reference model with a ring deadline.
module tb_call_controller;
    localparam int RT = 10;
    localparam logic [7:0] MY = 8'h01;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic [2:0] cmd;
    logic [7:0] cmd_addr;
    logic       cmd_ready;
    logic       net_tx_valid;
    logic [2:0] net_tx_type;
    logic [7:0] net_tx_dst;
    logic       net_tx_ready;
    logic       net_rx_valid;
    logic [2:0] net_rx_type;
    logic [7:0] net_rx_src;
    logic       net_rx_ready;
    logic       init;
    logic       incoming_call;
    logic [7:0] inc_address;
    logic [2:0] call_state;
    logic [7:0] peer_addr;

    int n_cmp  = 0;
    int n_fail = 0;

    call_controller #(.MY_ADDR(MY), .RING_TIMEOUT(16'(RT))) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd(cmd), .cmd_addr(cmd_addr), .cmd_ready(cmd_ready),
        .net_tx_valid(net_tx_valid), .net_tx_type(net_tx_type), .net_tx_dst(net_tx_dst),
        .net_tx_ready(net_tx_ready),
        .net_rx_valid(net_rx_valid), .net_rx_type(net_rx_type), .net_rx_src(net_rx_src),
        .net_rx_ready(net_rx_ready),
        .init(init), .incoming_call(incoming_call), .inc_address(inc_address),
        .call_state(call_state), .peer_addr(peer_addr)
    );

    always #5 clk = ~clk;

    // Reference model: call phase, sticky init, parties, outbox, ring deadline.
    int         edge_cnt = 0;
    int         m_state;
    bit         m_init;
    logic [7:0] m_peer, m_inc;
    bit         m_txv;
    logic [2:0] m_txt;
    logic [7:0] m_txd;
    int         m_entry;

    task automatic m_send(input logic [2:0] t, input logic [7:0] d);
        m_txv = 1'b1; m_txt = t; m_txd = d;
    endtask

    task automatic model_step();
        bit was_full, rx_ok, cmd_ok;
        edge_cnt++;
        if (reset) begin
            m_state = 5; m_init = 0; m_peer = 0; m_inc = 0;
            m_txv = 0; m_txt = 0; m_txd = 0; m_entry = edge_cnt;
            return;
        end
        was_full = m_txv;
        rx_ok  = net_rx_valid && !was_full;
        cmd_ok = cmd_valid && !was_full && !net_rx_valid;
        if (was_full && net_tx_ready) m_txv = 0;
        if (rx_ok) begin
            if (m_state == 5) begin
                if (net_rx_type == 0) begin m_init = 1; m_state = 0; end
            end else if (m_state == 0) begin
                if (net_rx_type == 1) begin
                    m_peer = net_rx_src; m_inc = net_rx_src; m_entry = edge_cnt; m_state = 1;
                end
            end else if (net_rx_type == 1 && net_rx_src != m_peer) begin
                m_send(3, net_rx_src);
            end else if (net_rx_src == m_peer) begin
                if ((m_state == 1 || m_state == 3) && net_rx_type == 4) m_state = 0;
                else if (m_state == 2 && net_rx_type == 2) m_state = 3;
                else if (m_state == 2 && net_rx_type == 3) m_state = 0;
            end
        end else if (cmd_ok) begin
            if (m_state == 5 && cmd == 0) begin
                m_send(0, 8'hFF); m_init = 1; m_state = 0;
            end else if (m_state == 0 && cmd == 1 && cmd_addr != MY && cmd_addr != 8'hFF) begin
                m_peer = cmd_addr; m_send(1, cmd_addr); m_entry = edge_cnt; m_state = 2;
            end else if (m_state == 1 && cmd == 2) begin
                m_send(2, m_peer); m_state = 3;
            end else if (m_state == 1 && cmd == 3) begin
                m_send(3, m_peer); m_state = 0;
            end else if ((m_state == 2 || m_state == 3) && cmd == 4) begin
                m_send(4, m_peer); m_state = 0;
            end
        end else if ((m_state == 1 || m_state == 2) && !was_full && (edge_cnt - m_entry >= RT)) begin
            m_send((m_state == 1) ? 3'd3 : 3'd4, m_peer);
            m_state = 0;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic send_cmd(input logic [2:0] c, input logic [7:0] a);
        cmd_valid = 1; cmd = c; cmd_addr = a;
        cycle();
        cmd_valid = 0;
    endtask

    task automatic send_rx(input logic [2:0] t, input logic [7:0] s);
        net_rx_valid = 1; net_rx_type = t; net_rx_src = s;
        cycle();
        net_rx_valid = 0;
    endtask

    task automatic drain();
        net_tx_ready = 1;
        cycle();
        net_tx_ready = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        cycle();
        cycle();
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({call_state, init, incoming_call, net_tx_valid, net_tx_type, net_tx_dst, inc_address, peer_addr, cmd_ready, net_rx_ready}
            !== {3'd5, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL reset: state=%0d init=%b inc=%b txv=%b type=%0d dst=%h inc_addr=%h peer=%h cr=%b rr=%b, want 5 0 0 0 0 00 00 00 1 1",
                     call_state, init, incoming_call, net_tx_valid, net_tx_type, net_tx_dst, inc_address, peer_addr, cmd_ready, net_rx_ready);
        end
    endtask

    task automatic test_init();
        send_cmd(3'd0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({call_state, init, net_tx_valid, net_tx_type, net_tx_dst, cmd_ready} !== {3'd0, 1'b1, 1'b1, 3'd0, 8'hFF, 1'b0}) begin
                n_fail++;
                $display("FAIL init_hold[%0d]: state=%0d init=%b txv=%b type=%0d dst=%h cr=%b, want 0 1 1 0 ff 0",
                         i, call_state, init, net_tx_valid, net_tx_type, net_tx_dst, cmd_ready);
            end
            if (i < 3) cycle();
        end
        drain();
        n_cmp++;
        if ({net_tx_valid, cmd_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL init_drain: txv=%b cr=%b, want 0 1", net_tx_valid, cmd_ready);
        end
    endtask

    task automatic test_outbound();
        send_cmd(3'd1, 8'h07);
        n_cmp++;
        if ({call_state, net_tx_valid, net_tx_type, net_tx_dst, peer_addr} !== {3'd2, 1'b1, 3'd1, 8'h07, 8'h07}) begin
            n_fail++;
            $display("FAIL out_dial: state=%0d txv=%b type=%0d dst=%h peer=%h, want 2 1 1 07 07",
                     call_state, net_tx_valid, net_tx_type, net_tx_dst, peer_addr);
        end
        drain();
        send_rx(3'd2, 8'h07);
        n_cmp++;
        if ({call_state, net_tx_valid} !== {3'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL out_ack: state=%0d txv=%b, want 3 0", call_state, net_tx_valid);
        end
        send_cmd(3'd4, 8'h00);
        n_cmp++;
        if ({call_state, net_tx_valid, net_tx_type, net_tx_dst} !== {3'd0, 1'b1, 3'd4, 8'h07}) begin
            n_fail++;
            $display("FAIL out_end: state=%0d txv=%b type=%0d dst=%h, want 0 1 4 07",
                     call_state, net_tx_valid, net_tx_type, net_tx_dst);
        end
        drain();
    endtask

    task automatic test_inbound_reject();
        send_rx(3'd1, 8'h22);
        n_cmp++;
        if ({call_state, incoming_call, inc_address, peer_addr, net_tx_valid} !== {3'd1, 1'b1, 8'h22, 8'h22, 1'b0}) begin
            n_fail++;
            $display("FAIL in_req: state=%0d inc=%b inc_addr=%h peer=%h txv=%b, want 1 1 22 22 0",
                     call_state, incoming_call, inc_address, peer_addr, net_tx_valid);
        end
        send_cmd(3'd3, 8'h00);
        n_cmp++;
        if ({call_state, incoming_call, net_tx_valid, net_tx_type, net_tx_dst, inc_address} !== {3'd0, 1'b0, 1'b1, 3'd3, 8'h22, 8'h22}) begin
            n_fail++;
            $display("FAIL in_reject: state=%0d inc=%b txv=%b type=%0d dst=%h inc_addr=%h, want 0 0 1 3 22 22",
                     call_state, incoming_call, net_tx_valid, net_tx_type, net_tx_dst, inc_address);
        end
        drain();
    endtask

    task automatic test_timeout();
        send_rx(3'd1, 8'h33);
        for (int k = 1; k < RT; k++) begin
            cycle();
            n_cmp++;
            if ({call_state, net_tx_valid} !== {3'd1, 1'b0}) begin
                n_fail++;
                $display("FAIL to_in_wait[%0d]: state=%0d txv=%b, want 1 0", k, call_state, net_tx_valid);
            end
        end
        cycle();
        n_cmp++;
        if ({call_state, net_tx_valid, net_tx_type, net_tx_dst} !== {3'd0, 1'b1, 3'd3, 8'h33}) begin
            n_fail++;
            $display("FAIL to_in_expire: state=%0d txv=%b type=%0d dst=%h, want 0 1 3 33",
                     call_state, net_tx_valid, net_tx_type, net_tx_dst);
        end
        drain();
        send_cmd(3'd1, 8'h44);
        drain();
        for (int k = 2; k < RT; k++) begin
            cycle();
            n_cmp++;
            if ({call_state, net_tx_valid} !== {3'd2, 1'b0}) begin
                n_fail++;
                $display("FAIL to_out_wait[%0d]: state=%0d txv=%b, want 2 0", k, call_state, net_tx_valid);
            end
        end
        cycle();
        n_cmp++;
        if ({call_state, net_tx_valid, net_tx_type, net_tx_dst} !== {3'd0, 1'b1, 3'd4, 8'h44}) begin
            n_fail++;
            $display("FAIL to_out_expire: state=%0d txv=%b type=%0d dst=%h, want 0 1 4 44",
                     call_state, net_tx_valid, net_tx_type, net_tx_dst);
        end
        drain();
    endtask

    task automatic test_busy_priority();
        send_cmd(3'd1, 8'h07);
        drain();
        send_rx(3'd2, 8'h07);
        net_rx_valid = 1; net_rx_type = 3'd1; net_rx_src = 8'h09;
        cmd_valid = 1; cmd = 3'd4; cmd_addr = 8'h00;
        #1;
        n_cmp++;
        if ({call_state, cmd_ready, net_rx_ready} !== {3'd3, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL prio_gate: state=%0d cr=%b rr=%b, want 3 0 1", call_state, cmd_ready, net_rx_ready);
        end
        cycle();
        net_rx_valid = 0;
        n_cmp++;
        if ({call_state, net_tx_valid, net_tx_type, net_tx_dst, cmd_ready} !== {3'd3, 1'b1, 3'd3, 8'h09, 1'b0}) begin
            n_fail++;
            $display("FAIL prio_nak: state=%0d txv=%b type=%0d dst=%h cr=%b, want 3 1 3 09 0",
                     call_state, net_tx_valid, net_tx_type, net_tx_dst, cmd_ready);
        end
        drain();
        n_cmp++;
        if ({call_state, net_tx_valid, cmd_ready} !== {3'd3, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL prio_drained: state=%0d txv=%b cr=%b, want 3 0 1", call_state, net_tx_valid, cmd_ready);
        end
        cycle();
        cmd_valid = 0;
        n_cmp++;
        if ({call_state, net_tx_valid, net_tx_type, net_tx_dst} !== {3'd0, 1'b1, 3'd4, 8'h07}) begin
            n_fail++;
            $display("FAIL prio_end: state=%0d txv=%b type=%0d dst=%h, want 0 1 4 07",
                     call_state, net_tx_valid, net_tx_type, net_tx_dst);
        end
        drain();
    endtask

    task automatic test_illegal();
        send_cmd(3'd1, MY);
        n_cmp++;
        if ({call_state, net_tx_valid} !== {3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL dial_self: state=%0d txv=%b, want 0 0", call_state, net_tx_valid);
        end
        send_cmd(3'd1, 8'hFF);
        n_cmp++;
        if ({call_state, net_tx_valid} !== {3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL dial_bcast: state=%0d txv=%b, want 0 0", call_state, net_tx_valid);
        end
        send_cmd(3'd1, 8'h07);
        drain();
        send_rx(3'd2, 8'h09);
        n_cmp++;
        if ({call_state, net_tx_valid} !== {3'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL ack_nonpeer: state=%0d txv=%b, want 2 0", call_state, net_tx_valid);
        end
        send_cmd(3'd4, 8'h00);
        drain();
    endtask

    function automatic logic [7:0] pick_addr(input logic [7:0] peer);
        case ($urandom_range(0, 5))
            0:       return MY;
            1:       return 8'h07;
            2:       return 8'h09;
            3:       return 8'hFF;
            default: return peer;
        endcase
    endfunction

    task automatic test_random();
        logic [34:0] got, want;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset        = ($urandom_range(0, 299) == 0);
            cmd_valid    = ($urandom_range(0, 9) < 3);
            cmd          = 3'($urandom_range(0, 7));
            cmd_addr     = pick_addr(m_peer);
            net_rx_valid = ($urandom_range(0, 9) < 2);
            net_rx_type  = 3'($urandom_range(0, 7));
            net_rx_src   = pick_addr(m_peer);
            net_tx_ready = ($urandom_range(0, 1) == 1);
            cycle();
            got  = {call_state, init, incoming_call, inc_address, peer_addr,
                    net_tx_valid, net_tx_type, net_tx_dst, cmd_ready, net_rx_ready};
            want = {3'(m_state), m_init, (m_state == 1), m_inc, m_peer,
                    m_txv, m_txt, m_txd, (!m_txv && !net_rx_valid), !m_txv};
            n_cmp++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h want %h (state/init/inc/inc_addr/peer/txv/type/dst/cr/rr)", i, got, want);
            end
        end
        reset = 0; cmd_valid = 0; net_rx_valid = 0; net_tx_ready = 0;
    endtask

    initial begin
        reset = 1; cmd_valid = 0; cmd = 0; cmd_addr = 0;
        net_tx_ready = 0; net_rx_valid = 0; net_rx_type = 0; net_rx_src = 0;
        @(negedge clk);
        test_reset();
        test_init();
        test_outbound();
        test_inbound_reject();
        test_timeout();
        test_busy_priority();
        test_illegal();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
